// File: rtl/anti_replay_pkg.sv
// rtl/anti_replay_pkg.sv - shared register map, status bits, LFSR constant and stamp FSM encoding
// Purpose: common definitions for anti_replay and anti_replay_stamp.
// Contents: 5-bit byte register offsets, STATUS bit indices, Galois LFSR
//           polynomial with its single-step helper, stamp FSM states.
package anti_replay_pkg;

  localparam logic [4:0] REG_TX_COUNTER = 5'h00;
  localparam logic [4:0] REG_TX_NONCE   = 5'h04;
  localparam logic [4:0] REG_SEED       = 5'h08;
  localparam logic [4:0] REG_STAMP      = 5'h0C;
  localparam logic [4:0] REG_STATUS     = 5'h10;
  localparam logic [4:0] REG_CACHE_SIZE = 5'h14;
  localparam logic [4:0] REG_CTRL       = 5'h18;

  localparam int STS_READY     = 0;
  localparam int STS_BUSY      = 1;
  localparam int STS_EXHAUSTED = 2;
  localparam int STS_COLLISION = 3;
  localparam int STS_OVERRUN   = 4;
  localparam int STS_FAIL      = 5;
  localparam int STS_W         = 6;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STEP   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } stamp_state_e;

  // One right-shifting Galois step: the bit shifted out decides the feedback.
  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    lfsr_next = cur >> 1;
    if (cur[0]) lfsr_next = lfsr_next ^ LFSR_POLY;
  endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// rtl/lfsr32_galois.sv - 32-bit Galois LFSR with synchronous load and step
// Purpose: nonce generator for the stamp engine.
// Ports: clk, rst_n (async active-low, state resets to 1),
//        load (state <= seed, wins over step), seed[31:0],
//        step (advance one Galois step), state[31:0] current value.
module lfsr32_galois
  import anti_replay_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= 32'h0000_0001;
    end else if (load) begin
      state <= seed;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/anti_replay_stamp.sv
// rtl/anti_replay_stamp.sv - transmit-side counter/nonce stamp engine on the 5-bit register bus
// Purpose: issues a monotonic 32-bit counter and a fresh LFSR nonce per packet,
//          rejecting nonces still held in a small FIFO cache of recent issues.
// Ports: clk, rst_n (async active-low), addr[4:0] byte offset, we write strobe,
//        wdata[31:0] write data, rdata[31:0] combinational read of addr.
module anti_replay_stamp
  import anti_replay_pkg::*;
#(
  parameter int CACHE_DEPTH = 4,
  parameter int MAX_RETRY   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  localparam int IDX_W = $clog2(CACHE_DEPTH);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CACHE_DEPTH - 1);
  localparam logic [RTY_W-1:0] RETRY_MAX = RTY_W'(MAX_RETRY);

  stamp_state_e      state_q;
  logic [31:0]       counter_q;
  logic [31:0]       nonce_q;
  logic [31:0]       seed_q;
  logic [STS_W-1:0]  status_q;
  logic [RTY_W-1:0]  retry_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  wptr_q;
  logic [CACHE_DEPTH-1:0] valid_q;
  logic [31:0]       cache_q [CACHE_DEPTH];
  logic [31:0]       lfsr_q;

  logic stamp_wr, seed_wr, ctrl_cache, ctrl_state, lfsr_step, hit;

  assign stamp_wr   = we && (addr == REG_STAMP);
  assign seed_wr    = we && (addr == REG_SEED);
  assign ctrl_cache = we && (addr == REG_CTRL) && wdata[0];
  assign ctrl_state = we && (addr == REG_CTRL) && wdata[1];
  assign lfsr_step  = (state_q == ST_STEP);

  // The LFSR output after STEP is the candidate nonce; it stays put through
  // CHECK and COMMIT because nothing else steps it there (a reload only comes
  // with CTRL bit1, which aborts the stamp anyway).
  assign hit = valid_q[idx_q] && (cache_q[idx_q] == lfsr_q);

  lfsr32_galois u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ctrl_state),
    .seed  (seed_q),
    .step  (lfsr_step),
    .state (lfsr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_q <= 32'h0000_0001;
    end else if (seed_wr) begin
      seed_q <= (wdata == 32'h0) ? 32'h0000_0001 : wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      counter_q <= 32'h0;
      nonce_q   <= 32'h0;
      status_q  <= '0;
      retry_q   <= '0;
      idx_q     <= '0;
      wptr_q    <= '0;
      valid_q   <= '0;
      for (int i = 0; i < CACHE_DEPTH; i++) cache_q[i] <= 32'h0;
    end else begin
      if (ctrl_state) begin
        counter_q <= 32'h0;
        nonce_q   <= 32'h0;
        status_q  <= '0;
        retry_q   <= '0;
        idx_q     <= '0;
        state_q   <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (stamp_wr && !status_q[STS_EXHAUSTED]) begin
              status_q[STS_READY] <= 1'b0;
              status_q[STS_BUSY]  <= 1'b1;
              retry_q             <= '0;
              state_q             <= ST_STEP;
            end
          end
          ST_STEP: begin
            idx_q   <= '0;
            state_q <= ST_CHECK;
          end
          ST_CHECK: begin
            if (hit) begin
              status_q[STS_COLLISION] <= 1'b1;
              if (retry_q < RETRY_MAX) begin
                retry_q <= retry_q + RTY_W'(1);
                state_q <= ST_STEP;
              end else begin
                status_q[STS_FAIL] <= 1'b1;
                status_q[STS_BUSY] <= 1'b0;
                state_q            <= ST_IDLE;
              end
            end else if (idx_q == LAST_IDX) begin
              state_q <= ST_COMMIT;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
          ST_COMMIT: begin
            counter_q          <= counter_q + 32'd1;
            nonce_q            <= lfsr_q;
            cache_q[wptr_q]    <= lfsr_q;
            valid_q[wptr_q]    <= 1'b1;
            wptr_q             <= wptr_q + IDX_W'(1);
            status_q[STS_READY] <= 1'b1;
            status_q[STS_BUSY]  <= 1'b0;
            // Saturate: once the last counter value is issued, no more stamps.
            if (counter_q == 32'hFFFF_FFFE) status_q[STS_EXHAUSTED] <= 1'b1;
            state_q            <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
        if (stamp_wr && (state_q != ST_IDLE)) status_q[STS_OVERRUN] <= 1'b1;
      end
      // Placed last so a cache clear wins over a same-cycle commit.
      if (ctrl_cache) begin
        valid_q <= '0;
        wptr_q  <= '0;
      end
    end
  end

  always_comb begin
    rdata = 32'h0;
    case (addr)
      REG_TX_COUNTER: rdata = counter_q;
      REG_TX_NONCE:   rdata = nonce_q;
      REG_SEED:       rdata = seed_q;
      REG_STATUS:     rdata = {{(32-STS_W){1'b0}}, status_q};
      REG_CACHE_SIZE: rdata = 32'(CACHE_DEPTH);
      default:        rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_anti_replay_stamp.sv
// tb/tb_anti_replay_stamp.sv - directed self-checking bench for anti_replay_stamp
module tb_anti_replay_stamp;
  import anti_replay_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata, rdata2;

  int errors = 0;
  int checks = 0;

  logic [31:0] last_ctr = 32'h0;
  logic [31:0] seen[$];
  bit          saw_busy;

  always #5 clk = ~clk;

  anti_replay_stamp #(.CACHE_DEPTH(4), .MAX_RETRY(4)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .we(we), .wdata(wdata), .rdata(rdata)
  );

  anti_replay_stamp #(.CACHE_DEPTH(4), .MAX_RETRY(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .we(we), .wdata(wdata), .rdata(rdata2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0; addr = REG_STATUS;
  endtask

  task automatic rd(input logic [4:0] a);
    addr = a;
    #1;
  endtask

  task automatic poll(input string tag);
    bit done = 1'b0;
    addr = REG_STATUS;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (!rdata[STS_BUSY] && !rdata2[STS_BUSY]) begin
        done = 1'b1;
        break;
      end
    end
    check({tag, "_done"}, {31'h0, done}, 32'h1);
  endtask

  // Receiver rule: counter strictly greater than the last, nonce never seen.
  task automatic rx_accept(input logic [31:0] ctr, input logic [31:0] nonce);
    bit ok = (ctr > last_ctr);
    foreach (seen[i]) if (seen[i] == nonce) ok = 1'b0;
    check("rx_accept", {31'h0, ok}, 32'h1);
    last_ctr = ctr;
    seen.push_back(nonce);
  endtask

  logic [31:0] c_tmp, n_tmp;

  initial begin
    rst_n = 1'b0; addr = REG_STATUS; we = 1'b0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state and constant registers
    rd(REG_TX_COUNTER); check("rst_counter", rdata, 32'h0);
    rd(REG_TX_NONCE);   check("rst_nonce", rdata, 32'h0);
    rd(REG_SEED);       check("rst_seed", rdata, 32'h1);
    rd(REG_STATUS);     check("rst_status", rdata, 32'h0);
    rd(REG_CACHE_SIZE); check("cache_size", rdata, 32'h4);
    rd(5'h1C);          check("unmapped_rd", rdata, 32'h0);
    rd(REG_STAMP);      check("stamp_rd", rdata, 32'h0);
    rd(REG_CTRL);       check("ctrl_rd", rdata, 32'h0);

    // First stamp, cycle-exact latency
    wr(REG_STAMP, 32'h0);
    rd(REG_STATUS); check("s1_busy0", rdata, 32'h2);
    repeat (5) @(negedge clk);
    rd(REG_STATUS); check("s1_busy5", rdata, 32'h2);
    @(negedge clk);
    rd(REG_STATUS); check("s1_ready6", rdata, 32'h1);
    check("s1_ready6_dut2", rdata2, 32'h1);
    rd(REG_TX_COUNTER); check("s1_counter", rdata, 32'h1); c_tmp = rdata;
    rd(REG_TX_NONCE);   check("s1_nonce", rdata, 32'h8020_0003); n_tmp = rdata;
    rx_accept(c_tmp, n_tmp);

    wr(REG_STAMP, 32'h0); poll("s2");
    rd(REG_TX_COUNTER); check("s2_counter", rdata, 32'h2); c_tmp = rdata;
    rd(REG_TX_NONCE);   check("s2_nonce", rdata, 32'hC030_0002); n_tmp = rdata;
    rx_accept(c_tmp, n_tmp);

    wr(REG_STAMP, 32'h0); poll("s3");
    rd(REG_TX_COUNTER); check("s3_counter", rdata, 32'h3); c_tmp = rdata;
    rd(REG_TX_NONCE);   check("s3_nonce", rdata, 32'h6018_0001); n_tmp = rdata;
    rx_accept(c_tmp, n_tmp);

    // State-only reset keeps the cache: the replayed sequence collides
    wr(REG_CTRL, 32'h2);
    rd(REG_STATUS);     check("c2_status", rdata, 32'h0);
    rd(REG_TX_COUNTER); check("c2_counter", rdata, 32'h0);
    wr(REG_STAMP, 32'h0); poll("coll");
    rd(REG_STATUS);     check("coll_status", rdata, 32'h09);
    check("coll_status_r1", rdata2, 32'h28);
    rd(REG_TX_COUNTER); check("coll_counter", rdata, 32'h1);
    check("coll_counter_r1", rdata2, 32'h0);
    rd(REG_TX_NONCE);   check("coll_nonce", rdata, 32'hB02C_0003);
    check("coll_nonce_r1", rdata2, 32'h0);

    // Overrun: second STAMP two cycles after the first
    wr(REG_CTRL, 32'h3);
    rd(REG_STATUS); check("c3a_status", rdata, 32'h0);
    check("c3a_status_r1", rdata2, 32'h0);
    wr(REG_STAMP, 32'h0);
    @(negedge clk);
    wr(REG_STAMP, 32'h0);
    poll("ovr");
    rd(REG_STATUS);     check("ovr_status", rdata, 32'h11);
    check("ovr_status_r1", rdata2, 32'h11);
    rd(REG_TX_COUNTER); check("ovr_counter", rdata, 32'h1);
    rd(REG_TX_NONCE);   check("ovr_nonce", rdata, 32'h8020_0003);
    wr(REG_CTRL, 32'h3);
    rd(REG_STATUS);     check("c3b_status", rdata, 32'h0);
    rd(REG_TX_COUNTER); check("c3b_counter", rdata, 32'h0);

    // Exhaustion
    @(negedge clk);
    dut.counter_q = 32'hFFFF_FFFE;
    rd(REG_TX_COUNTER); check("exh_deposit", rdata, 32'hFFFF_FFFE);
    wr(REG_STAMP, 32'h0); poll("exh");
    rd(REG_TX_COUNTER); check("exh_counter", rdata, 32'hFFFF_FFFF);
    rd(REG_STATUS);     check("exh_status", rdata, 32'h5);
    rd(REG_TX_NONCE);   check("exh_nonce", rdata, 32'h8020_0003);
    wr(REG_STAMP, 32'h0);
    saw_busy = 1'b0;
    addr = REG_STATUS;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (rdata[STS_BUSY]) saw_busy = 1'b1;
      @(negedge clk);
    end
    check("exh_no_busy", {31'h0, saw_busy}, 32'h0);
    rd(REG_STATUS);     check("exh_status2", rdata, 32'h5);
    rd(REG_TX_COUNTER); check("exh_counter2", rdata, 32'hFFFF_FFFF);

    // Seed handling: zero maps to 1, LFSR reloads only on CTRL bit1
    wr(REG_SEED, 32'h0);
    rd(REG_SEED); check("seed_zero", rdata, 32'h1);
    wr(REG_SEED, 32'h1234_5678);
    rd(REG_SEED); check("seed_val", rdata, 32'h1234_5678);
    wr(REG_CTRL, 32'h3);
    wr(REG_STAMP, 32'h0); poll("seed");
    rd(REG_TX_COUNTER); check("seed_counter", rdata, 32'h1);
    rd(REG_TX_NONCE);   check("seed_nonce", rdata, 32'h091A_2B3C);

    // Asynchronous reset in the middle of a stamp
    wr(REG_STAMP, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    rd(REG_STATUS);     check("arst_status", rdata, 32'h0);
    rd(REG_TX_COUNTER); check("arst_counter", rdata, 32'h0);
    rd(REG_SEED);       check("arst_seed", rdata, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    rd(REG_STATUS);     check("arst_idle", rdata, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
